// File: rtl/pingpong_read_sequencer.sv
// Read-side sequencer for the ping-pong sample buffer: fetches DEPTH samples and streams them out.
// Define PINGPONG_SEQ_STATS_EN to add the frame/abort statistics counters.
module pingpong_read_sequencer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             buffer_ready_i,
    input  logic             read_enable_i,
    input  logic [WIDTH-1:0] read_data_i,
    output logic             read_ack_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_first_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             overrun_o,
    input  logic             clear_i
`ifdef PINGPONG_SEQ_STATS_EN
    ,
    output logic [15:0]      frame_count_o,
    output logic [15:0]      abort_count_o
`endif
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [1:0]    WLOAD    = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;

    logic hs;
    logic is_last;
    logic swap_abort;

    assign hs      = (state_q == S_PRESENT) && m_ready_i;
    assign is_last = (idx_q == LAST_IDX);

    // A swap only aborts if it does not land on the final handshake.
    assign swap_abort = buffer_ready_i &&
                        ((state_q == S_WAIT) ||
                         ((state_q == S_PRESENT) && !(hs && is_last)));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        if (clear_i) begin
            overrun_d = 1'b0;
        end
        if (swap_abort) begin
            overrun_d = 1'b1;
        end

        if (swap_abort) begin
            state_d = S_WAIT;
            idx_d   = '0;
            wcnt_d  = WLOAD;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_i && read_enable_i) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                        wcnt_d  = WLOAD;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == 2'd0) begin
                        data_d  = read_data_i;
                        state_d = S_PRESENT;
                    end else begin
                        wcnt_d = wcnt_q - 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (hs) begin
                        if (is_last) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            wcnt_d  = WLOAD;
                            state_d = S_WAIT;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign read_ack_o = hs;
    assign m_valid_o  = (state_q == S_PRESENT);
    assign m_first_o  = m_valid_o && (idx_q == '0);
    assign m_last_o   = m_valid_o && is_last;
    assign m_data_o   = data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overrun_o  = overrun_q;

`ifdef PINGPONG_SEQ_STATS_EN
    logic [15:0] frame_q;
    logic [15:0] abort_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_q <= '0;
            abort_q <= '0;
        end else if (clear_i) begin
            frame_q <= '0;
            abort_q <= '0;
        end else begin
            if (hs && is_last && (frame_q != 16'hFFFF)) begin
                frame_q <= frame_q + 16'd1;
            end
            if (swap_abort && (abort_q != 16'hFFFF)) begin
                abort_q <= abort_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_q;
    assign abort_count_o = abort_q;
`endif

endmodule
